// File: rtl/datamem_dump_reader_pkg.sv
// Shared types and constants for the data-memory dump reader.
// Exports the FSM state encoding plus the word size and zero-word constants.
package dump_pkg;

  typedef enum logic [1:0] {
    MONITOR,
    FETCH,
    SEND,
    DONE
  } state_e;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ZERO_WORD  = 32'd0;

endpackage

// File: rtl/datamem_dump_reader_if.sv
// Valid/ready stream carrying {index, address, data} dump records.
// master drives valid/index/addr/data and samples ready; slave is the consumer.
interface datamem_dump_reader_if #(
  parameter int ADDR_W = 32
);

  logic              dout_valid;
  logic              dout_ready;
  logic [15:0]       dout_index;
  logic [ADDR_W-1:0] dout_addr;
  logic [31:0]       dout_data;

  modport master (
    output dout_valid,
    output dout_index,
    output dout_addr,
    output dout_data,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_index,
    input  dout_addr,
    input  dout_data,
    output dout_ready
  );

endinterface

// File: rtl/datamem_dump_reader_halt_detector.sv
// Halt detector: counts cycles with an all-zero instruction, cumulatively.
// Ports: clk, rst (async, active-high), inst (fetched word), halt (registered).
module halt_detector
  import dump_pkg::*;
#(
  parameter int HALT_COUNT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic        halt
);

  localparam logic [15:0] TERM = 16'(HALT_COUNT);

  logic [15:0] cnt_q, cnt_d;
  logic        halt_q, halt_d;

  // Nonzero instructions do not clear the count; it saturates at TERM.
  always_comb begin
    cnt_d = cnt_q;
    if (inst == ZERO_WORD && cnt_q != TERM)
      cnt_d = cnt_q + 16'd1;
    halt_d = (cnt_d == TERM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      halt_q <= halt_d;
    end
  end

  assign halt = halt_q;

endmodule

// File: rtl/datamem_dump_reader.sv
// Dump reader: after halt, owns the datamem port and streams words from 0.
// Ports: clk, rst, inst, mem_sel/mem_addr/mem_rdata, dout stream, done, dump_sum.
// Optional: define DUMP_SUM_EN to accumulate a wrap-around sum of sent words.
module datamem_dump_reader
  import dump_pkg::*;
#(
  parameter int HALT_COUNT = 10,
  parameter int ZERO_RUN   = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst,
  output logic                  mem_sel,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_rdata,
  datamem_dump_reader_if.master dout,
  output logic                  done,
  output logic [31:0]           dump_sum
);

  localparam int              SH   = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(MEM_DEPTH - WORD_BYTES);
  localparam logic [15:0]     ZRUN = 16'(ZERO_RUN);

  logic halt;

  halt_detector #(
    .HALT_COUNT(HALT_COUNT)
  ) u_halt (
    .clk (clk),
    .rst (rst),
    .inst(inst),
    .halt(halt)
  );

  state_e            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [15:0]       zrun_q, zrun_d;
  logic [15:0]       index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              accept;

  assign mem_addr = ADDR_W'(idx_q) << SH;
  assign accept   = (state_q == SEND) && dout.dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    zrun_d  = zrun_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      MONITOR: begin
        if (halt)
          state_d = FETCH;
      end
      FETCH: begin
        data_d  = mem_rdata;
        addr_d  = mem_addr;
        index_d = idx_q;
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          zrun_d = (data_q == ZERO_WORD) ?
                   zrun_q + 16'd1 : 16'd0;
          // End on a long enough zero run or the last word.
          if (zrun_d == ZRUN || addr_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MONITOR;
      idx_q   <= '0;
      zrun_q  <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      zrun_q  <= zrun_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_sel         = (state_q != MONITOR);
  assign done            = (state_q == DONE);
  assign dout.dout_valid = (state_q == SEND);
  assign dout.dout_index = index_q;
  assign dout.dout_addr  = addr_q;
  assign dout.dout_data  = data_q;

`ifdef DUMP_SUM_EN
  logic [31:0] sum_q, sum_d;

  // Only accepted words count; nothing is accepted once in DONE.
  always_comb begin
    sum_d = sum_q;
    if (accept)
      sum_d = sum_q + data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum_q <= '0;
    else
      sum_q <= sum_d;
  end

  assign dump_sum = sum_q;
`else
  assign dump_sum = 32'd0;
`endif

endmodule

// File: tb/tb_datamem_dump_reader.sv
// Directed bench for datamem_dump_reader with a behavioural data memory.
// Covers reset, halt counting, normal dump, backpressure, zero-run and end.
module tb_datamem_dump_reader;

  localparam logic [31:0] NOP = 32'h2002_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] dump_sum;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  datamem_dump_reader_if #(.ADDR_W(32)) dout();

  datamem_dump_reader #(
    .HALT_COUNT(10),
    .ZERO_RUN  (10),
    .MEM_DEPTH (1024),
    .ADDR_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .dout     (dout),
    .done     (done),
    .dump_sum (dump_sum)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = mem[mem_addr[9:2]];

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst = NOP;
    dout.dout_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic zeros10();
    repeat (10) begin
      inst = 32'd0;
      step();
    end
    inst = NOP;
  endtask

  function automatic logic [95:0] rec(input int n);
    logic [7:0] w;
    w = n[7:0];
    return {16'd0, 16'(n), 32'(4 * n), mem[w]};
  endfunction

  function automatic logic [95:0] cur();
    return {16'd0, dout.dout_index,
            dout.dout_addr, dout.dout_data};
  endfunction

  task automatic drain(input int first,
                       input int last,
                       input string tag);
    int n;
    int cyc;
    n = first;
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (dout.dout_valid && dout.dout_ready) begin
        chk({tag, "_word"}, cur(), rec(n));
        n++;
      end
      step();
      cyc++;
    end
    chk({tag, "_done"}, 96'(done), 96'(1));
    chk({tag, "_count"}, 96'(n), 96'(last + 1));
    chk({tag, "_valid_off"}, 96'(dout.dout_valid), 96'(0));
  endtask

  task automatic wait_idx(input int i, input string tag);
    int cyc;
    cyc = 0;
    while (!(dout.dout_valid && dout.dout_index == 16'(i))
           && cyc < 200) begin
      step();
      cyc++;
    end
    chk(tag, 96'(dout.dout_valid && dout.dout_index == 16'(i)),
        96'(1));
  endtask

  function automatic logic [31:0] sum_exp(input logic [31:0] s);
`ifdef DUMP_SUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  logic [95:0] snap;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h0000_0005;
    mem[1] = 32'hFFFF_FFFE;
    mem[2] = 32'h0000_0001;

    // Reset state
    do_reset();
    chk("rst_mem_sel", 96'(mem_sel), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_valid", 96'(dout.dout_valid), 96'(0));
    chk("rst_bundle", cur(), 96'(0));
    chk("rst_mem_addr", 96'(mem_addr), 96'(0));
    chk("rst_sum", 96'(dump_sum), 96'(0));

    // Nine zeros interleaved with real instructions
    for (int i = 0; i < 9; i++) begin
      inst = 32'd0;
      step();
      inst = NOP;
      step();
      chk("halt9_sel", 96'(mem_sel), 96'(0));
    end
    inst = 32'd0;
    step();
    inst = NOP;
    chk("term_sel", 96'(mem_sel), 96'(0));
    step();
    chk("fetch_sel", 96'(mem_sel), 96'(1));
    chk("fetch_valid", 96'(dout.dout_valid), 96'(0));
    step();
    chk("first_valid", 96'(dout.dout_valid), 96'(1));
    chk("first_rec", cur(), rec(0));

    drain(0, 12, "basic");
    chk("basic_sum", 96'(dump_sum), 96'(sum_exp(32'h4)));
    repeat (3) step();
    chk("done_sticky", 96'({done, mem_sel, dout.dout_valid}),
        96'(3'b110));

    // Backpressure on index 1
    do_reset();
    zeros10();
    wait_idx(1, "bp_reach1");
    dout.dout_ready = 1'b0;
    snap = cur();
    chk("bp_rec1", snap, rec(1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 96'(dout.dout_valid), 96'(1));
      chk("bp_hold_rec", cur(), rec(1));
    end
    dout.dout_ready = 1'b1;
    drain(1, 12, "bp");
    chk("bp_sum", 96'(dump_sum), 96'(sum_exp(32'h4)));

    // Zero-run restart, with a reset mid-SEND first
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[9] = 32'h0000_00A5;
    do_reset();
    zeros10();
    wait_idx(3, "mid_reach3");
    dout.dout_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 96'(dout.dout_valid), 96'(0));
    chk("mid_rst_sel", 96'(mem_sel), 96'(0));
    chk("mid_rst_done", 96'(done), 96'(0));
    chk("mid_rst_bundle", cur(), 96'(0));
    chk("mid_rst_sum", 96'(dump_sum), 96'(0));
    #2;
    rst = 1'b0;
    dout.dout_ready = 1'b1;
    step();
    zeros10();
    drain(0, 19, "zrun");
    chk("zrun_sum", 96'(dump_sum), 96'(sum_exp(32'hA5)));

    // End of memory with no zero run
    for (int i = 0; i < 256; i++) mem[i] = 32'd1;
    do_reset();
    zeros10();
    drain(0, 255, "eom");
    chk("eom_last", cur(), rec(255));
    chk("eom_sum", 96'(dump_sum), 96'(sum_exp(32'h100)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
